// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready flow control, zero/parity flags
// and a completed-op counter. Define LOGIC_POPCNT_EN to add a registered ones-count output.
`timescale 1ns/1ps
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] op_count
`ifdef LOGIC_POPCNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // A producer holds its data stable while valid is high and ready is low.

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s1_load;
    logic             s2_load;
    logic             out_xfer;
    logic [WIDTH-1:0] res;

    assign out_xfer = out_valid && out_ready;
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = in_valid && in_ready;

    always_comb begin
        res = '0;
        case (s1_op)
            3'b000:  res = s1_a & s1_b;
            3'b001:  res = s1_a | s1_b;
            3'b010:  res = s1_a ^ s1_b;
            3'b011:  res = ~s1_a;
            3'b100:  res = ~(s1_a & s1_b);
            3'b101:  res = ~(s1_a | s1_b);
            3'b110:  res = ~(s1_a ^ s1_b);
            default: res = s1_b;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_a     <= A;
                s1_b     <= B;
                s1_op    <= op;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Flags are derived from the S1 result so they register together with Y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            Y         <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                Y         <= res;
                zero      <= (res == '0);
                parity    <= ^res;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (out_xfer) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

`ifdef LOGIC_POPCNT_EN
    localparam int PC_W = $clog2(WIDTH+1);
    logic [PC_W-1:0] res_ones;

    always_comb begin
        res_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res_ones = res_ones + PC_W'(res[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            popcnt <= '0;
        end else if (s2_load) begin
            popcnt <= res_ones;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed vector table plus reset, back-pressure, streaming
// and counter-wrap sequences, with an ordered expected-result queue.
`timescale 1ns/1ps
module tb_logic_unit_pipe;

    localparam int W   = 8;
    localparam int CW  = 4;
    localparam int PCW = 4;
    localparam int EW  = W + 2 + PCW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [2:0]    op = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  Y;
    logic          zero;
    logic          parity;
    logic [CW-1:0] op_count;
`ifdef LOGIC_POPCNT_EN
    logic [PCW-1:0] popcnt;
`endif

    logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .Y(Y), .zero(zero), .parity(parity), .op_count(op_count)
`ifdef LOGIC_POPCNT_EN
        , .popcnt(popcnt)
`endif
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2:0]     o;
        logic [W-1:0]   y;
        logic           z;
        logic           p;
        logic [PCW-1:0] pc;
    } vec_t;

    vec_t            vecs[16];
    logic [EW-1:0]   exp_q[$];
    int              lat_q[$];
    logic [CW-1:0]   exp_cnt = '0;
    int              n_cmp = 0;
    int              n_err = 0;
    bit              lat_check = 1'b0;
    bit              tog_en = 1'b0;
    bit              hold_vld = 1'b0;
    logic [W+1:0]    hold_val;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] pack(input vec_t v);
        return {v.y, v.z, v.p, v.pc};
    endfunction

    function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] o);
        logic [W-1:0]   y;
        logic [PCW-1:0] c;
        case (o)
            3'd0: y = a & b;
            3'd1: y = a | b;
            3'd2: y = a ^ b;
            3'd3: y = ~a;
            3'd4: y = ~(a & b);
            3'd5: y = ~(a | b);
            3'd6: y = ~(a ^ b);
            default: y = b;
        endcase
        c = '0;
        for (int i = 0; i < W; i++) c = c + PCW'(y[i]);
        return {y, (y == '0), c[0], c};
    endfunction

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int t;
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'({Y, zero, parity}), 32'(hold_val));
            end
            hold_vld = out_valid && !out_ready;
            hold_val = {Y, zero, parity};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(Y), 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    t = lat_q.pop_front();
                    check("result_y", 32'(Y), 32'(e[EW-1:PCW+2]));
                    check("result_flags", 32'({zero, parity}), 32'(e[PCW+1:PCW]));
`ifdef LOGIC_POPCNT_EN
                    check("result_popcnt", 32'(popcnt), 32'(e[PCW-1:0]));
`endif
                    if (lat_check) check("latency", 32'(cyc - t), 32'd2);
                end
                check("op_count", 32'(op_count), 32'(exp_cnt));
                exp_cnt = exp_cnt + 1'b1;
            end
        end
    end

    always @(posedge clk) if (tog_en) #1 out_ready = 1'($urandom_range(0, 1));

    // driver tasks
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                        input logic [EW-1:0] ev);
        int n = 0;
        bit acc = 1'b0;
        A = a; B = b; op = o; in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ev);
                lat_q.push_back(cyc);
                acc = 1'b1;
            end
            n++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [W-1:0] a = W'($urandom_range(0, 255));
        logic [W-1:0] b = W'($urandom_range(0, 255));
        logic [2:0]   o = 3'($urandom_range(0, 7));
        send(a, b, o, model(a, b, o));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        lat_q.delete();
        exp_cnt = '0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(Y), 32'd0);
        check("rst_flags", 32'({zero, parity}), 32'b10);
        check("rst_op_count", 32'(op_count), 32'd0);
`ifdef LOGIC_POPCNT_EN
        check("rst_popcnt", 32'(popcnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid_after", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int c0;
        vecs[0]  = '{8'hC5, 8'h3A, 3'd0, 8'h00, 1'b1, 1'b0, 4'd0};
        vecs[1]  = '{8'hC5, 8'h3A, 3'd1, 8'hFF, 1'b0, 1'b0, 4'd8};
        vecs[2]  = '{8'hC5, 8'h3A, 3'd2, 8'hFF, 1'b0, 1'b0, 4'd8};
        vecs[3]  = '{8'hC5, 8'h3A, 3'd3, 8'h3A, 1'b0, 1'b0, 4'd4};
        vecs[4]  = '{8'hC5, 8'h3A, 3'd4, 8'hFF, 1'b0, 1'b0, 4'd8};
        vecs[5]  = '{8'hC5, 8'h3A, 3'd5, 8'h00, 1'b1, 1'b0, 4'd0};
        vecs[6]  = '{8'hC5, 8'h3A, 3'd6, 8'h00, 1'b1, 1'b0, 4'd0};
        vecs[7]  = '{8'hC5, 8'h3A, 3'd7, 8'h3A, 1'b0, 1'b0, 4'd4};
        vecs[8]  = '{8'hF0, 8'h0F, 3'd1, 8'hFF, 1'b0, 1'b0, 4'd8};
        vecs[9]  = '{8'hF0, 8'h0F, 3'd0, 8'h00, 1'b1, 1'b0, 4'd0};
        vecs[10] = '{8'h81, 8'h01, 3'd2, 8'h80, 1'b0, 1'b1, 4'd1};
        vecs[11] = '{8'h12, 8'h34, 3'd3, 8'hED, 1'b0, 1'b0, 4'd6};
        vecs[12] = '{8'h12, 8'h34, 3'd7, 8'h34, 1'b0, 1'b1, 4'd3};
        vecs[13] = '{8'h96, 8'h5A, 3'd6, 8'h33, 1'b0, 1'b0, 4'd4};
        vecs[14] = '{8'h0F, 8'h3C, 3'd4, 8'hF3, 1'b0, 1'b0, 4'd6};
        vecs[15] = '{8'h81, 8'h40, 3'd5, 8'h3E, 1'b0, 1'b1, 4'd5};

        @(posedge clk); #1;
        do_reset();

        // directed vector table, back to back with out_ready high
        out_ready = 1'b1;
        lat_check = 1'b1;
        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].o, pack(vecs[i]));
        drain();

        // reset with two ops in flight
        send_rand();
        send_rand();
        do_reset();
        repeat (4) begin
            @(negedge clk);
            check("no_stale_after_rst", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;

        // back-pressure: two accepted, third stalls until S2 drains
        lat_check = 1'b0;
        out_ready = 1'b0;
        send(vecs[1].a, vecs[1].b, vecs[1].o, pack(vecs[1]));
        send(vecs[11].a, vecs[11].b, vecs[11].o, pack(vecs[11]));
        A = vecs[15].a; B = vecs[15].b; op = vecs[15].o; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_y_first", 32'(Y), 32'(vecs[1].y));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_on_drain", 32'(in_ready), 32'd1);
        exp_q.push_back(pack(vecs[15]));
        lat_q.push_back(cyc);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // streaming: 100 ops back to back, one accept per cycle
        do_reset();
        out_ready = 1'b1;
        lat_check = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 100; i++) send_rand();
        check("stream_cycles", 32'(cyc - c0), 32'd100);
        drain();
        check("stream_op_count", 32'(op_count), 32'd4);

        // counter wrap with random out_ready
        do_reset();
        lat_check = 1'b0;
        tog_en = 1'b1;
        for (int i = 0; i < 17; i++) send_rand();
        tog_en = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();
        check("wrap_op_count", 32'(op_count), 32'd1);

        repeat (3) @(posedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
